note_frame_sched: RTL and testbench

Frame scheduler for the pitch/duration datapath. Counts 5 kHz ADC sample strobes into 512-sample frames, launches the FFT, waits for the pitch result, and issues exactly one single-cycle `note_dec` pulse per frame to the note-duration detector. It captures the completed duration code the cycle after the pulse and queues (note, duration) events in a small FIFO, which the MCU-side interface drains with a ready/valid handshake.

---
 rtl/note_frame_sched_pkg.sv | 31 +++
 rtl/note_frame_sched_if.sv | 22 ++
 rtl/note_frame_sched_evt_fifo.sv | 75 +++++++
 rtl/note_frame_sched.sv | 218 +++++++++++++++++++++
 tb/tb_note_frame_sched.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/note_frame_sched_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : note_pkg
// Purpose  : Shared types and constants for the note frame scheduler:
//            scheduler FSM state encoding, the queued note event record and
//            the one-hot duration codes produced by the duration detector.
// Revision : 1.0 - initial release
// ============================================================================
package note_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FFT_RUN    = 3'd1,
        ST_PITCH_WAIT = 3'd2,
        ST_DECIDE     = 3'd3,
        ST_CAPTURE    = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic [7:0] note;
        logic [3:0] dur;
    } note_evt_t;

    localparam logic [3:0] EIGHTH  = 4'b0001;
    localparam logic [3:0] QUARTER = 4'b0010;
    localparam logic [3:0] HALF    = 4'b0100;
    localparam logic [3:0] WHOLE   = 4'b1000;

endpackage
`default_nettype wire

// File: rtl/note_frame_sched_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : note_frame_sched_if
// Purpose  : Ready/valid event bus between the scheduler's event FIFO and
//            the MCU-side consumer.
//   evt_valid  head event present        (master -> slave)
//   evt_ready  consumer accepts the head (slave  -> master)
//   evt_note   head event note code      (master -> slave)
//   evt_dur    head event duration code  (master -> slave)
// Revision : 1.0 - initial release
// ============================================================================
interface note_frame_sched_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_note;
    logic [3:0] evt_dur;

    modport master (output evt_valid, output evt_note, output evt_dur, input evt_ready);
    modport slave  (input evt_valid, input evt_note, input evt_dur, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/note_frame_sched_evt_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : note_evt_fifo
// Purpose  : First-word-fall-through FIFO of note events. The head entry is
//            presented combinationally whenever the FIFO is non-empty. A push
//            while full succeeds only when a pop happens in the same cycle.
// Ports    : clk, reset (async, active-low)
//            i_push / i_push_data : write request and event
//            i_pop                : consume head (ignored when empty)
//            o_head               : current head event
//            o_empty / o_full     : occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module note_evt_fifo
    import note_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      i_push,
    input  note_evt_t i_push_data,
    input  logic      i_pop,
    output note_evt_t o_head,
    output logic      o_empty,
    output logic      o_full
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_ONE   = c_PTR_W'(1);

    note_evt_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_DEPTH);
    assign w_pop_ok  = i_pop && !o_empty;
    // Full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/note_frame_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : note_frame_sched
// Purpose  : Frame scheduler for the pitch/duration datapath. Counts ADC
//            sample strobes into frames, launches the FFT, waits for the
//            pitch result, pulses note_dec once per frame, captures the
//            duration code and queues (previous note, duration) events.
// Ports    : clk, reset (async, active-low)
//            sample_valid          ADC sample strobe
//            fft_start / fft_done  FFT launch pulse / completion strobe
//            pitch_valid, pitch_note  pitch result
//            note, note_dec        note code and decision pulse to detector
//            note_dur              one-hot duration code from detector
//            evt                   ready/valid event bus (master side)
//            clr_err               clear sticky flags
//            frame_ovr, evt_drop, timeout_err  sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module note_frame_sched
    import note_pkg::*;
#(
    parameter int FRAME_LEN = 512,
    parameter int EVT_DEPTH = 8,
    parameter int TIMEOUT   = 65535
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_valid,
    output logic                      fft_start,
    input  logic                      fft_done,
    input  logic                      pitch_valid,
    input  logic [7:0]                pitch_note,
    output logic [7:0]                note,
    output logic                      note_dec,
    input  logic [3:0]                note_dur,
    note_frame_sched_if.master        evt,
    input  logic                      clr_err,
    output logic                      frame_ovr,
    output logic                      evt_drop,
    output logic                      timeout_err
);

    localparam int                  c_CNT_W    = $clog2(FRAME_LEN);
    localparam logic [c_CNT_W-1:0]  c_CNT_MAX  = c_CNT_W'(FRAME_LEN - 1);
    localparam int                  c_WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(TIMEOUT);

    sched_state_t        r_state;
    sched_state_t        w_state_nxt;
    logic [c_CNT_W-1:0]  r_sample_cnt;
    logic [c_WAIT_W-1:0] r_wait;
    logic [7:0]          r_note;
    logic [7:0]          r_last_note;
    logic                r_fft_start;
    logic                r_note_dec;
    logic                r_frame_ovr;
    logic                r_evt_drop;
    logic                r_timeout_err;

    logic                w_frame_done;
    logic                w_fft_start_nxt;
    logic                w_note_dec_nxt;
    logic                w_latch_note;
    logic                w_capture;
    logic                w_push;
    logic                w_wait_clr;
    logic                w_timeout;
    logic                w_ovr_set;
    logic                w_drop_set;
    logic                w_pop;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    note_evt_t           w_push_evt;
    note_evt_t           w_head;

    // The wrap of the sample counter is the frame boundary.
    assign w_frame_done = sample_valid && (r_sample_cnt == c_CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sample_cnt <= '0;
        end else if (sample_valid) begin
            r_sample_cnt <= (r_sample_cnt == c_CNT_MAX) ? '0 : r_sample_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_fft_start_nxt = 1'b0;
        w_note_dec_nxt  = 1'b0;
        w_latch_note    = 1'b0;
        w_capture       = 1'b0;
        w_wait_clr      = 1'b0;
        w_timeout       = 1'b0;
        // A frame ending while the previous one is still in flight is dropped.
        w_ovr_set       = w_frame_done && (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_frame_done) begin
                    w_state_nxt     = ST_FFT_RUN;
                    w_fft_start_nxt = 1'b1;
                    w_wait_clr      = 1'b1;
                end
            end
            ST_FFT_RUN: begin
                if (fft_done) begin
                    w_state_nxt = ST_PITCH_WAIT;
                    w_wait_clr  = 1'b1;
                end else if (r_wait == c_WAIT_MAX) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            ST_PITCH_WAIT: begin
                if (pitch_valid) begin
                    w_state_nxt    = ST_DECIDE;
                    w_latch_note   = 1'b1;
                    w_note_dec_nxt = 1'b1;
                end else if (r_wait == c_WAIT_MAX) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            ST_DECIDE: begin
                w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pulses are registered so they track the state register exactly and
    // drop immediately on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fft_start <= 1'b0;
            r_note_dec  <= 1'b0;
            r_wait      <= '0;
            r_note      <= '0;
            r_last_note <= '0;
        end else begin
            r_fft_start <= w_fft_start_nxt;
            r_note_dec  <= w_note_dec_nxt;
            if (w_wait_clr) begin
                r_wait <= '0;
            end else if ((r_state == ST_FFT_RUN) || (r_state == ST_PITCH_WAIT)) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_latch_note) begin
                r_note <= pitch_note;
            end
            if (w_capture) begin
                r_last_note <= r_note;
            end
        end
    end

    // The event pairs the previous frame's note with the duration just
    // reported for it.
    assign w_push          = w_capture && (note_dur != 4'b0000);
    assign w_push_evt.note = r_last_note;
    assign w_push_evt.dur  = note_dur;
    assign w_pop           = !w_fifo_empty && evt.evt_ready;
    assign w_drop_set      = w_push && w_fifo_full && !w_pop;

    note_evt_fifo #(
        .DEPTH (EVT_DEPTH)
    ) u_evt_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_evt),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    // Set beats clear when both occur in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_ovr   <= 1'b0;
            r_evt_drop    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_frame_ovr   <= w_ovr_set  || (r_frame_ovr   && !clr_err);
            r_evt_drop    <= w_drop_set || (r_evt_drop    && !clr_err);
            r_timeout_err <= w_timeout  || (r_timeout_err && !clr_err);
        end
    end

    assign fft_start     = r_fft_start;
    assign note_dec      = r_note_dec;
    assign note          = r_note;
    assign frame_ovr     = r_frame_ovr;
    assign evt_drop      = r_evt_drop;
    assign timeout_err   = r_timeout_err;
    assign evt.evt_valid = !w_fifo_empty;
    // Keep the event outputs at zero while nothing is queued.
    assign evt.evt_note  = w_fifo_empty ? 8'h00 : w_head.note;
    assign evt.evt_dur   = w_fifo_empty ? 4'h0  : w_head.dur;

endmodule
`default_nettype wire

// File: tb/tb_note_frame_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_note_frame_sched
// Purpose  : Self-checking bench for note_frame_sched. Directed frames drive
//            the FFT/pitch/duration handshakes; expected events are queued
//            as they are generated and a negedge monitor compares every
//            accepted event against the queue head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_frame_sched;
    import note_pkg::*;

    localparam int FRAME_LEN = 512;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_valid = 1'b0;
    logic       fft_start;
    logic       fft_done = 1'b0;
    logic       pitch_valid = 1'b0;
    logic [7:0] pitch_note = 8'h00;
    logic [7:0] note;
    logic       note_dec;
    logic [3:0] note_dur = 4'h0;
    logic       clr_err = 1'b0;
    logic       frame_ovr;
    logic       evt_drop;
    logic       timeout_err;

    note_frame_sched_if evt_if ();

    note_frame_sched u_dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .fft_start    (fft_start),
        .fft_done     (fft_done),
        .pitch_valid  (pitch_valid),
        .pitch_note   (pitch_note),
        .note         (note),
        .note_dec     (note_dec),
        .note_dur     (note_dur),
        .evt          (evt_if.master),
        .clr_err      (clr_err),
        .frame_ovr    (frame_ovr),
        .evt_drop     (evt_drop),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int        total = 0;
    int        bad   = 0;
    int        n_fft = 0;
    int        n_dec = 0;
    note_evt_t exp_q[$];
    logic [7:0] last_model = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted event must match the queue head.
    initial begin
        note_evt_t e;
        forever begin
            @(negedge clk);
            if (fft_start === 1'b1) n_fft++;
            if (note_dec === 1'b1) n_dec++;
            if (evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL evt_pop: got %0h/%0h, required no event",
                             evt_if.evt_note, evt_if.evt_dur);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_pop", {evt_if.evt_note, evt_if.evt_dur}, {e.note, e.dur});
                end
            end
        end
    end

    // Returns just after the edge that takes the last strobe of the frame.
    task automatic send_frame();
        for (int i = 0; i < FRAME_LEN; i++) begin
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
    endtask

    // One full frame; expect_drop marks an event the full FIFO must discard.
    task automatic run_frame(input logic [7:0] nt, input logic [3:0] dur,
                             input logic rdy, input logic expect_drop);
        note_evt_t e;
        send_frame();
        @(negedge clk);
        chk("fft_start_pulse", fft_start, 1);
        chk("note_dec_idle", note_dec, 0);
        tick();
        chk("fft_start_width", fft_start, 0);
        fft_done = 1'b1;
        tick();
        fft_done    = 1'b0;
        pitch_valid = 1'b1;
        pitch_note  = nt;
        tick();
        pitch_valid = 1'b0;
        pitch_note  = 8'hFF;
        @(negedge clk);
        chk("note_dec_high", note_dec, 1);
        chk("note_value", note, nt);
        tick();
        note_dur = dur;
        if (rdy) evt_if.evt_ready = 1'b1;
        @(negedge clk);
        chk("note_dec_width", note_dec, 0);
        tick();
        note_dur          = 4'h0;
        evt_if.evt_ready  = 1'b0;
        if (dur != 4'h0 && !expect_drop) begin
            e.note = last_model;
            e.dur  = dur;
            exp_q.push_back(e);
        end
        last_model = nt;
    endtask

    initial begin
        logic [3:0] durs [8];
        int n;
        durs = '{EIGHTH, QUARTER, HALF, WHOLE, WHOLE, HALF, QUARTER, EIGHTH};
        evt_if.evt_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pulses", {fft_start, note_dec}, 0);
        chk("rst_note", note, 0);
        chk("rst_evt", {evt_if.evt_valid, evt_if.evt_note, evt_if.evt_dur}, 0);
        chk("rst_flags", {frame_ovr, evt_drop, timeout_err}, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // First frame: last_note is 0, zero duration queues nothing
        run_frame(8'h3C, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("no_evt_dur0", evt_if.evt_valid, 0);
        tick();

        // Second frame: event {0x3C, QUARTER} three cycles after pitch_valid
        run_frame(8'h40, QUARTER, 1'b0, 1'b0);
        @(negedge clk);
        chk("evt_valid_lat", evt_if.evt_valid, 1);
        chk("evt_head", {evt_if.evt_note, evt_if.evt_dur}, {8'h3C, QUARTER});
        tick();
        evt_if.evt_ready = 1'b1;
        tick();
        evt_if.evt_ready = 1'b0;
        @(negedge clk);
        chk("evt_valid_fall", evt_if.evt_valid, 0);
        tick();

        // Fill all eight slots without draining
        for (int i = 0; i < 8; i++) begin
            run_frame(8'h41 + 8'(i), durs[i], 1'b0, 1'b0);
        end
        @(negedge clk);
        chk("drop_before_full", evt_drop, 0);
        tick();

        // Ninth event is lost, head untouched
        run_frame(8'h49, HALF, 1'b0, 1'b1);
        @(negedge clk);
        chk("evt_drop_set", evt_drop, 1);
        chk("head_after_drop", {evt_if.evt_note, evt_if.evt_dur}, {8'h40, EIGHTH});
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        @(negedge clk);
        chk("evt_drop_clr", evt_drop, 0);
        tick();

        // Push while full with a same-cycle pop: no drop
        run_frame(8'h4A, WHOLE, 1'b1, 1'b0);
        @(negedge clk);
        chk("no_drop_with_pop", evt_drop, 0);
        tick();
        evt_if.evt_ready = 1'b1;
        repeat (8) tick();
        evt_if.evt_ready = 1'b0;
        @(negedge clk);
        chk("drained_valid", evt_if.evt_valid, 0);
        chk("drained_queue", exp_q.size(), 0);
        tick();

        // Timeout with an overrunning frame in FFT_RUN
        send_frame();
        @(negedge clk);
        chk("to_fft_start", fft_start, 1);
        chk("ovr_before", frame_ovr, 0);
        tick();
        send_frame();
        @(negedge clk);
        chk("frame_ovr_set", frame_ovr, 1);
        chk("ovr_no_fft_start", fft_start, 0);
        n = 0;
        while (timeout_err !== 1'b1 && n < 70000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_err_set", timeout_err, 1);
        chk("timeout_no_dec", n_dec, 12);
        tick();

        // FSM is back in IDLE: a normal frame runs end to end
        run_frame(8'h50, WHOLE, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_to_evt", {evt_if.evt_valid, evt_if.evt_note, evt_if.evt_dur},
            {1'b1, 8'h4A, WHOLE});
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        @(negedge clk);
        chk("flags_clr", {frame_ovr, evt_drop, timeout_err}, 0);
        tick();
        evt_if.evt_ready = 1'b1;
        tick();
        evt_if.evt_ready = 1'b0;
        @(negedge clk);
        chk("final_empty", evt_if.evt_valid, 0);
        chk("final_queue", exp_q.size(), 0);
        chk("fft_start_count", n_fft, 14);
        chk("note_dec_count", n_dec, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
